// File: rtl/mult_unit_pkg.sv
// Shared definitions for the multiply unit.
//  - MIPS R-type function codes that route to this unit (MULT/MULTU).
//  - Multiplier FSM state encoding.
//  - Helper that sizes the iteration counter from the operand width.
package mult_unit_pkg;

  // R-type function codes decoded upstream into Mult_en.
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_FIN  = 2'd2
  } mul_state_e;

  // Counter width needed to count DATA_W-1 down to 0.
  function automatic int mul_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mult_unit_abs.sv
// mult_abs: conditional two's complement of a W-bit value.
//  Used for operand magnitudes (neg_i = signed & sign bit) and for
//  negating the 2W-bit product when the operand signs differ.
// Ports:
//  val_i  in  W  value to transform
//  neg_i  in  1  1 = return ~val_i + 1, 0 = pass through
//  res_o  out W  result (unsigned interpretation; |MIN| stays MIN, which is correct)
module mult_abs
  import mult_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_unit.sv
// mult_unit: multi-cycle shift-add multiplier with architectural HI/LO.
//  A start request in IDLE latches operand magnitudes and the result sign,
//  then DATA_W RUN cycles each add the shifted multiplicand when the current
//  multiplier bit is set. FIN writes {hi,lo} (negated if needed) and pulses done.
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  start               one-cycle request, honoured only in IDLE
//  mul_signed          1 = MULT (signed), 0 = MULTU; sampled with start
//  rs_val, rt_val      multiplicand / multiplier; sampled with start
//  busy                state != IDLE (core stall request)
//  done                one-cycle pulse, hi/lo already hold the new product
//  hi, lo              HI/LO architectural registers
//  state_dbg           current FSM state (mul_state_e encoding)
// Handshake: start is a request with no back-pressure beyond busy; a start seen
//  while busy is dropped, so the core must hold off until busy is low. The cycle
//  done is high is IDLE, so a new start there is accepted with no bubble.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mul_signed,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = mul_cnt_w(DATA_W);
  localparam int PW    = 2 * DATA_W;

  mul_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PW-1:0]       mcand_q;   // multiplicand, shifted left each RUN cycle
  logic [DATA_W-1:0]   mplier_q;  // multiplier, shifted right each RUN cycle
  logic [PW-1:0]       acc_q;
  logic [PW-1:0]       acc_d;
  logic                neg_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic                done_q;

  logic [DATA_W-1:0]   rs_mag;
  logic [DATA_W-1:0]   rt_mag;
  logic [PW-1:0]       prod_fin;

  mult_abs #(.W(DATA_W)) u_abs_rs (
    .val_i (rs_val),
    .neg_i (mul_signed & rs_val[DATA_W-1]),
    .res_o (rs_mag)
  );

  mult_abs #(.W(DATA_W)) u_abs_rt (
    .val_i (rt_val),
    .neg_i (mul_signed & rt_val[DATA_W-1]),
    .res_o (rt_mag)
  );

  // Final sign fix-up of the unsigned magnitude product.
  mult_abs #(.W(PW)) u_neg_prod (
    .val_i (acc_q),
    .neg_i (neg_q),
    .res_o (prod_fin)
  );

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MUL_IDLE: begin
          if (start) begin
            mcand_q  <= {{DATA_W{1'b0}}, rs_mag};
            mplier_q <= rt_mag;
            neg_q    <= mul_signed & (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
            acc_q    <= '0;
            cnt_q    <= CNT_W'(DATA_W - 1);
            state_q  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_q <= MUL_FIN;
        end
        MUL_FIN: begin
          {hi_q, lo_q} <= prod_fin;
          done_q       <= 1'b1;
          state_q      <= MUL_IDLE;
        end
        default: state_q <= MUL_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != MUL_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mult_unit.sv
// Testbench for mult_unit: directed vector table, multi-cycle corner
// sequences (start while busy, reset mid-run, back-to-back) and a short
// random run against a 64-bit product model.
module tb_mult_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mul_signed;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  mult_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mul_signed (mul_signed),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Caller sits at a negedge. Issues one start, then watches until done
  // (bounded), checking latency, busy in the done cycle, HI/LO hold and result.
  // inj > 0 pulses a second start (MULTU 9*9) in that busy cycle.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input string nm, input int inj);
    logic [31:0] ph;
    logic [31:0] pl;
    int nb;
    bit seen;
    bit hold_ok;
    ph = hi; pl = lo; nb = 0; seen = 0; hold_ok = 1;
    mul_signed = s; rs_val = a; rt_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nb++;
      if (hi !== ph || lo !== pl) hold_ok = 0;
      if (c == inj) begin
        mul_signed = 1'b0; rs_val = 32'd9; rt_val = 32'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({nm, " done_seen"}, 64'(seen), 64'd1);
    check({nm, " busy_cycles"}, 64'(nb), 64'd33);
    check({nm, " busy_in_done"}, 64'(busy), 64'd0);
    check({nm, " hold"}, 64'(hold_ok), 64'd1);
    check({nm, " hilo"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    logic [63:0] p;
    logic        rs;
    logic [31:0] ra;
    logic [31:0] rb;
    int          nd;

    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[4] = '{1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[5] = '{1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[6] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vecs[7] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[8] = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    vecs[9] = '{1'b0, 32'h12345678, 32'h00000001, 32'h00000000, 32'h12345678};

    rst = 1'b1; start = 1'b0; mul_signed = 1'b0; rs_val = '0; rt_val = '0;

    // 1: reset state, then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst hilo", {hi, lo}, 64'd0);
    check("rst busy_done", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle hilo", {hi, lo}, 64'd0);
    check("idle busy_done", {62'd0, busy, done}, 64'd0);

    // 2/3: directed vector table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
             $sformatf("vec%0d", i), 0);
      @(negedge clk);
    end

    // 4: start while busy is ignored; exactly one done
    run_op(1'b0, 32'd7, 32'd6, 32'd0, 32'h2A, "ignore", 10);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("ignore extra_done", 64'(nd), 64'd0);
    check("ignore hilo_after", {hi, lo}, {32'd0, 32'h2A});

    // 5: reset in RUN aborts, clears HI/LO, no done
    mul_signed = 1'b0; rs_val = 32'd7; rt_val = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst busy", 64'(busy), 64'd0);
    check("mid_rst hilo", {hi, lo}, 64'd0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("mid_rst no_done", 64'(nd), 64'd0);
    run_op(1'b0, 32'd3, 32'd4, 32'd0, 32'hC, "after_rst", 0);
    @(negedge clk);

    // 6: back-to-back, second start issued in the done cycle
    run_op(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, "b2b_first", 0);
    run_op(1'b1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, "b2b_second", 0);
    @(negedge clk);

    // random run against the 64-bit model
    for (int i = 0; i < 150; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom();
      rb = $urandom();
      if (i % 10 == 0) ra = 32'h80000000;
      if (i % 15 == 0) rb = 32'hFFFFFFFF;
      p = model(rs, ra, rb);
      run_op(rs, ra, rb, p[63:32], p[31:0], $sformatf("rnd%0d", i), 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
